// File: rtl/hash_table.sv
// Chained hash table with a single command in flight.
// Each bucket head points into a shared pool of data entries. Entries in the
// same bucket form a singly linked list, and new keys are linked in at the
// head. A FIFO of free entry pointers hands out storage and takes it back.
// After reset, the INIT state clears the head table and loads the free FIFO,
// then the block accepts commands.
module hash_table #(
  parameter int    KEY_WIDTH        = 32,
  parameter int    VALUE_WIDTH      = 16,
  parameter int    BUCKET_WIDTH     = 8,
  parameter int    TABLE_ADDR_WIDTH = 8,
  parameter string HASH_TYPE        = "dummy"
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    ht_cmd_in_valid,
  output logic                    ht_cmd_in_ready,
  input  logic [1:0]              ht_cmd_in_opcode,
  input  logic [KEY_WIDTH-1:0]    ht_cmd_in_key,
  input  logic [VALUE_WIDTH-1:0]  ht_cmd_in_value,
  output logic                    ht_res_out_valid,
  input  logic                    ht_res_out_ready,
  output logic [1:0]              ht_res_out_opcode,
  output logic [KEY_WIDTH-1:0]    ht_res_out_key,
  output logic [VALUE_WIDTH-1:0]  ht_res_out_value,
  output logic [2:0]              ht_res_out_rescode,
  output logic [BUCKET_WIDTH-1:0] ht_res_out_bucket
);

  localparam int NumBuckets = 1 << BUCKET_WIDTH;
  localparam int NumEntries = 1 << TABLE_ADDR_WIDTH;
  localparam int InitWidth  = (BUCKET_WIDTH > TABLE_ADDR_WIDTH) ? BUCKET_WIDTH : TABLE_ADDR_WIDTH;

  localparam logic [1:0] OpSearch = 2'd0;
  localparam logic [1:0] OpInsert = 2'd1;
  localparam logic [1:0] OpDelete = 2'd2;
  localparam logic [1:0] OpRsvd   = 2'd3;

  localparam logic [2:0] RcSearchFound   = 3'd0;
  localparam logic [2:0] RcSearchNoEntry = 3'd1;
  localparam logic [2:0] RcInsertOk      = 3'd2;
  localparam logic [2:0] RcInsertSameKey = 3'd3;
  localparam logic [2:0] RcInsertFull    = 3'd4;
  localparam logic [2:0] RcDeleteOk      = 3'd5;
  localparam logic [2:0] RcDeleteNoEntry = 3'd6;
  localparam logic [2:0] RcUnknownOp     = 3'd7;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_READ_HEAD, S_READ_ENTRY, S_UPDATE, S_RESP
  } state_t;

  function automatic logic [BUCKET_WIDTH-1:0] bucketOf(input logic [KEY_WIDTH-1:0] key);
    if (HASH_TYPE == "dummy") return key[KEY_WIDTH-1 -: BUCKET_WIDTH];
    else                      return key[BUCKET_WIDTH-1:0];
  endfunction

  // Control and command registers
  state_t                    state_q, state_d;
  logic [InitWidth-1:0]      initCnt_q, initCnt_d;
  logic [1:0]                cmdOp_q, cmdOp_d;
  logic [KEY_WIDTH-1:0]      cmdKey_q, cmdKey_d;
  logic [VALUE_WIDTH-1:0]    cmdValue_q, cmdValue_d;
  logic [TABLE_ADDR_WIDTH-1:0] curPtr_q, curPtr_d;
  logic                      hasPred_q, hasPred_d;
  logic [TABLE_ADDR_WIDTH-1:0] predPtr_q, predPtr_d;
  logic [KEY_WIDTH-1:0]      predKey_q, predKey_d;
  logic [VALUE_WIDTH-1:0]    predValue_q, predValue_d;
  logic                      matched_q, matched_d;
  logic [2:0]                resCode_q, resCode_d;
  logic [VALUE_WIDTH-1:0]    resValue_q, resValue_d;
  logic [TABLE_ADDR_WIDTH-1:0] fifoWr_q, fifoWr_d;
  logic [TABLE_ADDR_WIDTH-1:0] fifoRd_q, fifoRd_d;
  logic [TABLE_ADDR_WIDTH:0]   fifoCnt_q, fifoCnt_d;

  // Storage arrays and their registered read data
  logic                        headValidMem [NumBuckets];
  logic [TABLE_ADDR_WIDTH-1:0] headPtrMem   [NumBuckets];
  logic [KEY_WIDTH-1:0]        dataKeyMem   [NumEntries];
  logic [VALUE_WIDTH-1:0]      dataValueMem [NumEntries];
  logic                        dataNvMem    [NumEntries];
  logic [TABLE_ADDR_WIDTH-1:0] dataNpMem    [NumEntries];
  logic [TABLE_ADDR_WIDTH-1:0] fifoMem      [NumEntries];

  logic                        headRdValid_q;
  logic [TABLE_ADDR_WIDTH-1:0] headRdPtr_q;
  logic [KEY_WIDTH-1:0]        entKey_q;
  logic [VALUE_WIDTH-1:0]      entValue_q;
  logic                        entNextValid_q;
  logic [TABLE_ADDR_WIDTH-1:0] entNextPtr_q;
  logic [TABLE_ADDR_WIDTH-1:0] fifoHead_q;

  // Storage access controls
  logic [BUCKET_WIDTH-1:0]     cmdBucket;
  logic [BUCKET_WIDTH-1:0]     headRaddr, headWaddr;
  logic                        headWe, headWvalid;
  logic [TABLE_ADDR_WIDTH-1:0] headWptr;
  logic [TABLE_ADDR_WIDTH-1:0] dataRaddr, dataWaddr;
  logic                        dataWe, dataWnv;
  logic [KEY_WIDTH-1:0]        dataWkey;
  logic [VALUE_WIDTH-1:0]      dataWvalue;
  logic [TABLE_ADDR_WIDTH-1:0] dataWnp;
  logic                        fifoPush, fifoPop;
  logic [TABLE_ADDR_WIDTH-1:0] fifoWdata;
  logic                        missed;

  assign cmdBucket          = bucketOf(cmdKey_q);
  assign ht_res_out_valid   = (state_q == S_RESP);
  assign ht_res_out_opcode  = cmdOp_q;
  assign ht_res_out_key     = cmdKey_q;
  assign ht_res_out_bucket  = cmdBucket;
  assign ht_res_out_value   = resValue_q;
  assign ht_res_out_rescode = resCode_q;

  // Next-state logic: the FSM walks the bucket chain and schedules every table
  // and FIFO write. The head and data read addresses are held steady while a
  // command is in flight, so the registered read data always describes the
  // current bucket head and the current chain entry.
  always_comb begin
    state_d     = state_q;
    initCnt_d   = initCnt_q;
    cmdOp_d     = cmdOp_q;
    cmdKey_d    = cmdKey_q;
    cmdValue_d  = cmdValue_q;
    curPtr_d    = curPtr_q;
    hasPred_d   = hasPred_q;
    predPtr_d   = predPtr_q;
    predKey_d   = predKey_q;
    predValue_d = predValue_q;
    matched_d   = matched_q;
    resCode_d   = resCode_q;
    resValue_d  = resValue_q;
    fifoWr_d    = fifoWr_q;
    fifoRd_d    = fifoRd_q;
    fifoCnt_d   = fifoCnt_q;

    headRaddr  = (state_q == S_IDLE) ? bucketOf(ht_cmd_in_key) : cmdBucket;
    headWe     = 1'b0;
    headWaddr  = cmdBucket;
    headWvalid = 1'b0;
    headWptr   = headRdPtr_q;
    dataRaddr  = curPtr_q;
    dataWe     = 1'b0;
    dataWaddr  = curPtr_q;
    dataWkey   = entKey_q;
    dataWvalue = entValue_q;
    dataWnv    = entNextValid_q;
    dataWnp    = entNextPtr_q;
    fifoPush   = 1'b0;
    fifoPop    = 1'b0;
    fifoWdata  = curPtr_q;
    missed     = 1'b0;
    ht_cmd_in_ready = 1'b0;

    case (state_q)
      S_INIT: begin
        headWe     = (int'(initCnt_q) < NumBuckets);
        headWaddr  = initCnt_q[BUCKET_WIDTH-1:0];
        headWvalid = 1'b0;
        fifoPush   = (int'(initCnt_q) < NumEntries);
        fifoWdata  = initCnt_q[TABLE_ADDR_WIDTH-1:0];
        initCnt_d  = initCnt_q + 1'b1;
        if (initCnt_q == '1) state_d = S_IDLE;
      end
      S_IDLE: begin
        ht_cmd_in_ready = 1'b1;
        if (ht_cmd_in_valid) begin
          cmdOp_d    = ht_cmd_in_opcode;
          cmdKey_d   = ht_cmd_in_key;
          cmdValue_d = ht_cmd_in_value;
          hasPred_d  = 1'b0;
          matched_d  = 1'b0;
          if (ht_cmd_in_opcode == OpRsvd) begin
            resCode_d  = RcUnknownOp;
            resValue_d = '0;
            state_d    = S_RESP;
          end else begin
            state_d = S_READ_HEAD;
          end
        end
      end
      S_READ_HEAD: begin
        if (headRdValid_q) begin
          curPtr_d  = headRdPtr_q;
          dataRaddr = headRdPtr_q;
          state_d   = S_READ_ENTRY;
        end else begin
          missed = 1'b1;
        end
      end
      S_READ_ENTRY: begin
        if (entKey_q == cmdKey_q) begin
          matched_d = 1'b1;
          if (cmdOp_q == OpSearch) begin
            resCode_d  = RcSearchFound;
            resValue_d = entValue_q;
            state_d    = S_RESP;
          end else begin
            state_d = S_UPDATE;
          end
        end else if (entNextValid_q) begin
          hasPred_d   = 1'b1;
          predPtr_d   = curPtr_q;
          predKey_d   = entKey_q;
          predValue_d = entValue_q;
          curPtr_d    = entNextPtr_q;
          dataRaddr   = entNextPtr_q;
        end else begin
          missed = 1'b1;
        end
      end
      S_UPDATE: begin
        state_d = S_RESP;
        if (cmdOp_q == OpInsert && matched_q) begin
          dataWe     = 1'b1;
          dataWvalue = cmdValue_q;
          resCode_d  = RcInsertSameKey;
          resValue_d = cmdValue_q;
        end else if (cmdOp_q == OpInsert) begin
          fifoPop    = 1'b1;
          dataWe     = 1'b1;
          dataWaddr  = fifoHead_q;
          dataWkey   = cmdKey_q;
          dataWvalue = cmdValue_q;
          dataWnv    = headRdValid_q;
          dataWnp    = headRdPtr_q;
          headWe     = 1'b1;
          headWvalid = 1'b1;
          headWptr   = fifoHead_q;
          resCode_d  = RcInsertOk;
          resValue_d = cmdValue_q;
        end else begin
          if (hasPred_q) begin
            dataWe     = 1'b1;
            dataWaddr  = predPtr_q;
            dataWkey   = predKey_q;
            dataWvalue = predValue_q;
          end else begin
            headWe     = 1'b1;
            headWvalid = entNextValid_q;
            headWptr   = entNextPtr_q;
          end
          fifoPush   = 1'b1;
          fifoWdata  = curPtr_q;
          resCode_d  = RcDeleteOk;
          resValue_d = '0;
        end
      end
      S_RESP: begin
        if (ht_res_out_ready) state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase

    if (missed) begin
      resValue_d = '0;
      state_d    = S_RESP;
      case (cmdOp_q)
        OpSearch: resCode_d = RcSearchNoEntry;
        OpDelete: resCode_d = RcDeleteNoEntry;
        OpInsert: begin
          if (fifoCnt_q != '0) state_d = S_UPDATE;
          else                 resCode_d = RcInsertFull;
        end
        default:  resCode_d = RcUnknownOp;
      endcase
    end

    if (fifoPush) begin
      fifoWr_d  = fifoWr_q + 1'b1;
      fifoCnt_d = fifoCnt_q + 1'b1;
    end
    if (fifoPop) begin
      fifoRd_d  = fifoRd_q + 1'b1;
      fifoCnt_d = fifoCnt_q - 1'b1;
    end
  end

  // Control registers; reset aborts any command and restarts table initialisation
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_INIT;
      initCnt_q   <= '0;
      cmdOp_q     <= '0;
      cmdKey_q    <= '0;
      cmdValue_q  <= '0;
      curPtr_q    <= '0;
      hasPred_q   <= 1'b0;
      predPtr_q   <= '0;
      predKey_q   <= '0;
      predValue_q <= '0;
      matched_q   <= 1'b0;
      resCode_q   <= '0;
      resValue_q  <= '0;
      fifoWr_q    <= '0;
      fifoRd_q    <= '0;
      fifoCnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      initCnt_q   <= initCnt_d;
      cmdOp_q     <= cmdOp_d;
      cmdKey_q    <= cmdKey_d;
      cmdValue_q  <= cmdValue_d;
      curPtr_q    <= curPtr_d;
      hasPred_q   <= hasPred_d;
      predPtr_q   <= predPtr_d;
      predKey_q   <= predKey_d;
      predValue_q <= predValue_d;
      matched_q   <= matched_d;
      resCode_q   <= resCode_d;
      resValue_q  <= resValue_d;
      fifoWr_q    <= fifoWr_d;
      fifoRd_q    <= fifoRd_d;
      fifoCnt_q   <= fifoCnt_d;
    end
  end

  // Head, data and free-pointer RAMs with one-cycle synchronous read
  always_ff @(posedge clk_i) begin
    if (!rst_i && headWe) begin
      headValidMem[headWaddr] <= headWvalid;
      headPtrMem[headWaddr]   <= headWptr;
    end
    if (!rst_i && dataWe) begin
      dataKeyMem[dataWaddr]   <= dataWkey;
      dataValueMem[dataWaddr] <= dataWvalue;
      dataNvMem[dataWaddr]    <= dataWnv;
      dataNpMem[dataWaddr]    <= dataWnp;
    end
    if (!rst_i && fifoPush) begin
      fifoMem[fifoWr_q] <= fifoWdata;
    end
    headRdValid_q  <= headValidMem[headRaddr];
    headRdPtr_q    <= headPtrMem[headRaddr];
    entKey_q       <= dataKeyMem[dataRaddr];
    entValue_q     <= dataValueMem[dataRaddr];
    entNextValid_q <= dataNvMem[dataRaddr];
    entNextPtr_q   <= dataNpMem[dataRaddr];
    fifoHead_q     <= fifoMem[fifoRd_q];
  end

endmodule

// File: tb/tb_hash_table.sv
// Scoreboard bench for hash_table: the driver queues the expected result of
// every accepted command, and an independent monitor compares each result
// handshake against the head of that queue.
module tb_hash_table;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmdValid;
  logic        cmdReady;
  logic [1:0]  cmdOpcode;
  logic [31:0] cmdKey;
  logic [15:0] cmdValue;
  logic        resValid;
  logic        resReady;
  logic [1:0]  resOpcode;
  logic [31:0] resKey;
  logic [15:0] resValue;
  logic [2:0]  resRescode;
  logic [7:0]  resBucket;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] key;
    logic [15:0] value;
    logic [2:0]  code;
    bit          checkValue;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  bit   toggleReady = 1'b0;

  hash_table dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .ht_cmd_in_valid    (cmdValid),
    .ht_cmd_in_ready    (cmdReady),
    .ht_cmd_in_opcode   (cmdOpcode),
    .ht_cmd_in_key      (cmdKey),
    .ht_cmd_in_value    (cmdValue),
    .ht_res_out_valid   (resValid),
    .ht_res_out_ready   (resReady),
    .ht_res_out_opcode  (resOpcode),
    .ht_res_out_key     (resKey),
    .ht_res_out_value   (resValue),
    .ht_res_out_rescode (resRescode),
    .ht_res_out_bucket  (resBucket)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Result-side backpressure: always ready, or a coin flip each cycle
  initial begin
    resReady = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      resReady = toggleReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compare each result handshake with the scoreboard and check that
  // results hold while stalled and drop right after being taken
  initial begin
    exp_t        e;
    bit          holdValid = 1'b0;
    bit          expectDrop = 1'b0;
    logic [60:0] held = '0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        holdValid  = 1'b0;
        expectDrop = 1'b0;
      end else if (expectDrop) begin
        checkOutput("valid_drop", {63'b0, resValid}, 64'd0);
        expectDrop = 1'b0;
      end else if (resValid === 1'b1) begin
        if (holdValid)
          checkOutput("stall_hold", {3'b0, resOpcode, resKey, resValue, resRescode, resBucket}, {3'b0, held});
        if (resReady === 1'b1) begin
          holdValid  = 1'b0;
          expectDrop = 1'b1;
          if (expQ.size() == 0) begin
            checkOutput("unexpected_result", {61'b0, resRescode}, 64'hFFFF);
          end else begin
            e = expQ.pop_front();
            checkOutput("rescode", {61'b0, resRescode}, {61'b0, e.code});
            checkOutput("echo", {30'b0, resOpcode, resKey}, {30'b0, e.op, e.key});
            checkOutput("bucket", {56'b0, resBucket}, {56'b0, e.key[31:24]});
            if (e.checkValue)
              checkOutput("value", {48'b0, resValue}, {48'b0, e.value});
          end
        end else begin
          holdValid = 1'b1;
          held      = {resOpcode, resKey, resValue, resRescode, resBucket};
        end
      end
    end
  end

  // Issue one command, queueing its expected result just before the accepting edge
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] key, input logic [15:0] value,
                               input logic [2:0] code, input logic [15:0] expValue, input bit checkVal);
    exp_t e;
    int   n = 0;
    cmdValid  = 1'b1;
    cmdOpcode = op;
    cmdKey    = key;
    cmdValue  = value;
    while (cmdReady !== 1'b1 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (cmdReady !== 1'b1) begin
      checkOutput("cmd_ready_timeout", {63'b0, cmdReady}, 64'd1);
      cmdValid = 1'b0;
      return;
    end
    e.op = op; e.key = key; e.value = expValue; e.code = code; e.checkValue = checkVal;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    cmdValid = 1'b0;
  endtask

  // Cycles from the accepting edge until the result appears
  task automatic probeLatency(input string name, input int expLat);
    int n = 0;
    while (resValid !== 1'b1 && n < 600) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput(name, 64'(n + 1), 64'(expLat));
  endtask

  // Wait until every queued expectation has been consumed
  task automatic drain();
    int n = 0;
    while ((expQ.size() != 0 || resValid === 1'b1) && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain_pending", 64'(expQ.size()), 64'd0);
  endtask

  // Reset, check the reset outputs, then time the initialisation sweep
  task automatic doReset();
    int n = 0;
    rst      = 1'b1;
    cmdValid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_ready", {63'b0, cmdReady}, 64'd0);
    checkOutput("reset_valid", {63'b0, resValid}, 64'd0);
    checkOutput("reset_fields", {3'b0, resOpcode, resKey, resValue, resRescode, resBucket}, 64'd0);
    rst = 1'b0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (cmdReady !== 1'b1 && n < 1000);
    checkOutput("init_cycles", 64'(n), 64'd256);
  endtask

  localparam logic [1:0] S = 2'd0, I = 2'd1, D = 2'd2, R = 2'd3;

  initial begin
    logic [15:0] rv;
    logic [31:0] key;
    bit          mValid [128];
    logic [15:0] mVal   [128];
    int          idx, sel, nAbort;
    logic [1:0]  op;
    logic [2:0]  code;
    logic [15:0] val, expv;
    bit          chk;

    rst = 1'b1; cmdValid = 1'b0; cmdOpcode = '0; cmdKey = '0; cmdValue = '0;
    doReset();

    // Overwrite of an existing key in a two-entry chain
    rv = 16'($urandom_range(0, 65535));
    applyStimulus(I, 32'h01000000, 16'h1234, 3'd2, 16'h1234, 1'b0);
    applyStimulus(I, 32'h01001000, 16'h1235, 3'd2, 16'h1235, 1'b0);
    applyStimulus(I, 32'h01000000, rv,       3'd3, rv,       1'b1);
    applyStimulus(S, 32'h01000000, 16'h0,    3'd0, rv,       1'b1);

    // Delete the tail of chain 01000001 -> 01001000 -> 01000000
    applyStimulus(I, 32'h01000001, 16'h5A5A, 3'd2, 16'h5A5A, 1'b0);
    applyStimulus(D, 32'h01000000, 16'h0,    3'd5, 16'h0,    1'b1);
    applyStimulus(S, 32'h01000000, 16'h0,    3'd1, 16'h0,    1'b1);
    applyStimulus(S, 32'h01000001, 16'h0,    3'd0, 16'h5A5A, 1'b1);
    applyStimulus(S, 32'h01000001, 16'h0,    3'd0, 16'h5A5A, 1'b1);
    applyStimulus(S, 32'h01000003, 16'h0,    3'd1, 16'h0,    1'b1);
    applyStimulus(S, 32'h01001000, 16'h0,    3'd0, 16'h1235, 1'b1);
    applyStimulus(R, 32'h12345678, 16'hFFFF, 3'd7, 16'h0,    1'b1);
    drain();

    // Reset right after an INSERT is accepted: no result, table emptied
    cmdValid = 1'b1; cmdOpcode = I; cmdKey = 32'h04000000; cmdValue = 16'h7777;
    nAbort = 0;
    while (cmdReady !== 1'b1 && nAbort < 100) begin
      @(posedge clk);
      #1;
      nAbort++;
    end
    @(posedge clk);
    #1;
    doReset();

    // Fresh table misses, then a single entry with non-matching keys in its bucket
    applyStimulus(S, 32'h04000000, 16'h0, 3'd1, 16'h0, 1'b1);
    probeLatency("lat_empty_search", 2);
    applyStimulus(S, 32'h01001000, 16'h0, 3'd1, 16'h0, 1'b1);
    applyStimulus(D, 32'h04111111, 16'h0, 3'd6, 16'h0, 1'b0);
    applyStimulus(I, 32'h04000000, 16'h0400, 3'd2, 16'h0400, 1'b0);
    probeLatency("lat_insert_empty", 3);
    applyStimulus(S, 32'h04100000, 16'h0, 3'd1, 16'h0, 1'b1);
    probeLatency("lat_search_miss1", 3);
    applyStimulus(D, 32'h04100000, 16'h0, 3'd6, 16'h0, 1'b0);
    applyStimulus(S, 32'h04000000, 16'h0, 3'd0, 16'h0400, 1'b1);

    // Buckets 0..3: insert, search in reverse, delete, delete again
    for (int i = 0; i < 4; i++)
      applyStimulus(I, {8'(i), 24'h0}, 16'(16'h10 + i), 3'd2, 16'(16'h10 + i), 1'b0);
    for (int i = 3; i >= 0; i--)
      applyStimulus(S, {8'(i), 24'h0}, 16'h0, 3'd0, 16'(16'h10 + i), 1'b1);
    for (int i = 0; i < 4; i++)
      applyStimulus(D, {8'(i), 24'h0}, 16'h0, 3'd5, 16'h0, 1'b1);
    for (int i = 0; i < 4; i++)
      applyStimulus(D, {8'(i), 24'h0}, 16'h0, 3'd6, 16'h0, 1'b0);

    // Head delete, then a true middle-of-chain delete in 03 -> 02 -> 00
    applyStimulus(I, 32'h05000000, 16'hA000, 3'd2, 16'hA000, 1'b0);
    applyStimulus(I, 32'h05000001, 16'hA001, 3'd2, 16'hA001, 1'b0);
    probeLatency("lat_insert_chain1", 4);
    applyStimulus(D, 32'h05000001, 16'h0,    3'd5, 16'h0,    1'b1);
    applyStimulus(I, 32'h05000002, 16'hA002, 3'd2, 16'hA002, 1'b0);
    applyStimulus(I, 32'h05000003, 16'hA003, 3'd2, 16'hA003, 1'b0);
    applyStimulus(S, 32'h05000000, 16'h0,    3'd0, 16'hA000, 1'b1);
    applyStimulus(S, 32'h05000001, 16'h0,    3'd1, 16'h0,    1'b1);
    applyStimulus(S, 32'h05000002, 16'h0,    3'd0, 16'hA002, 1'b1);
    applyStimulus(S, 32'h05000003, 16'h0,    3'd0, 16'hA003, 1'b1);
    applyStimulus(D, 32'h05000002, 16'h0,    3'd5, 16'h0,    1'b1);
    applyStimulus(S, 32'h05000000, 16'h0,    3'd0, 16'hA000, 1'b1);
    applyStimulus(S, 32'h05000003, 16'h0,    3'd0, 16'hA003, 1'b1);
    applyStimulus(S, 32'h05000002, 16'h0,    3'd1, 16'h0,    1'b1);
    drain();

    // Fill all 256 entries, one per bucket, then exercise the full table
    doReset();
    for (int i = 0; i < 256; i++)
      applyStimulus(I, {8'(i), 16'h0, 8'(i)}, 16'(16'h8000 + i), 3'd2, 16'(16'h8000 + i), 1'b0);
    applyStimulus(I, 32'h2A0000FF, 16'h1111, 3'd4, 16'h0,    1'b0);
    applyStimulus(I, 32'h2A00002A, 16'hBEEF, 3'd3, 16'hBEEF, 1'b1);
    applyStimulus(D, 32'h05000005, 16'h0,    3'd5, 16'h0,    1'b1);
    applyStimulus(I, 32'h2A0000FF, 16'h1111, 3'd2, 16'h1111, 1'b0);
    applyStimulus(I, 32'h2B0000FF, 16'h2222, 3'd4, 16'h0,    1'b0);
    applyStimulus(S, 32'h2A0000FF, 16'h0,    3'd0, 16'h1111, 1'b1);
    applyStimulus(S, 32'h2A00002A, 16'h0,    3'd0, 16'hBEEF, 1'b1);
    applyStimulus(S, 32'h05000005, 16'h0,    3'd1, 16'h0,    1'b1);
    drain();

    // Shuffled traffic over 16 buckets x 8 keys against a reference model
    doReset();
    for (int i = 0; i < 128; i++) begin
      mValid[i] = 1'b0;
      mVal[i]   = '0;
    end
    toggleReady = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      idx = $urandom_range(0, 127);
      sel = $urandom_range(0, 15);
      key = {8'(idx / 8), 16'h0, 8'(idx % 8)};
      val = 16'($urandom_range(0, 65535));
      op  = (sel == 0) ? R : 2'(sel % 3);
      chk = 1'b1;
      expv = 16'h0;
      case (op)
        S: begin
          code = mValid[idx] ? 3'd0 : 3'd1;
          expv = mValid[idx] ? mVal[idx] : 16'h0;
        end
        I: begin
          code = mValid[idx] ? 3'd3 : 3'd2;
          expv = val;
          chk  = mValid[idx];
          mValid[idx] = 1'b1;
          mVal[idx]   = val;
        end
        D: begin
          code = mValid[idx] ? 3'd5 : 3'd6;
          chk  = mValid[idx];
          mValid[idx] = 1'b0;
        end
        default: code = 3'd7;
      endcase
      applyStimulus(op, key, val, code, expv, chk);
    end
    drain();
    toggleReady = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog in case the design stops accepting or responding altogether
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
